// File: rtl/dac712_update_sequencer_if.sv
// dac712_update_sequencer_if: sample handshake, clear request and DAC712 pin bundle.
interface dac712_update_sequencer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clr_req;
    logic [15:0] dac_data;
    logic [3:0]  ic_com;
    logic        wr_done;
    logic        clr_done;
    logic        busy;
    logic [15:0] update_count;
    modport master (
        output in_data, in_valid, clr_req,
        input  in_ready, dac_data, ic_com, wr_done, clr_done, busy, update_count
    );
    modport slave (
        input  in_data, in_valid, clr_req,
        output in_ready, dac_data, ic_com, wr_done, clr_done, busy, update_count
    );
endinterface

// File: rtl/dac712_update_sequencer.sv
// dac712_update_sequencer: timed double-buffer write and clear sequencing for a DAC712.
module dac712_update_sequencer #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 1
) (
    input logic clk,
    input logic rst,
    dac712_update_sequencer_if.slave s
);
    typedef enum logic [2:0] {IDLE, SETUP, WR_IN, HOLD_IN, WR_DAC, HOLD_DAC, CLEAR, HOLD_CLR} state_t;
    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        clr_pend, last, go_clr, accept;
    logic [15:0] data_q, upd_cnt;
    logic [3:0]  ic_q;
    logic        wr_done_q, clr_done_q;
    function automatic logic [7:0] dur(state_t st);
        case (st)
            SETUP:                     dur = 8'(SETUP_CYC - 1);
            WR_IN, WR_DAC, CLEAR:      dur = 8'(PULSE_CYC - 1);
            HOLD_IN, HOLD_DAC, HOLD_CLR: dur = 8'(HOLD_CYC - 1);
            default:                   dur = 8'd0;
        endcase
    endfunction
    // {A0_n, A1_n, WR_n, CLR_n}
    function automatic logic [3:0] com(state_t st);
        com = st == WR_IN ? 4'b0101 : st == WR_DAC ? 4'b1001 : st == CLEAR ? 4'b1110 : 4'b1111;
    endfunction
    assign s.in_ready     = state == IDLE && !clr_pend && !s.clr_req;
    assign s.dac_data     = data_q;
    assign s.ic_com       = ic_q;
    assign s.wr_done      = wr_done_q;
    assign s.clr_done     = clr_done_q;
    assign s.busy         = state != IDLE;
    assign s.update_count = upd_cnt;
    always_comb begin
        state_n = state;
        last    = cnt == 8'd0;
        go_clr  = state == IDLE && (clr_pend || s.clr_req);
        accept  = s.in_valid && s.in_ready;
        case (state)
            IDLE:     state_n = go_clr ? CLEAR : accept ? SETUP : IDLE;
            SETUP:    state_n = last ? WR_IN : SETUP;
            WR_IN:    state_n = last ? HOLD_IN : WR_IN;
            HOLD_IN:  state_n = last ? WR_DAC : HOLD_IN;
            WR_DAC:   state_n = last ? HOLD_DAC : WR_DAC;
            HOLD_DAC: state_n = last ? IDLE : HOLD_DAC;
            CLEAR:    state_n = last ? HOLD_CLR : CLEAR;
            HOLD_CLR: state_n = last ? IDLE : HOLD_CLR;
            default:  state_n = IDLE;
        endcase
        cnt_n = state_n != state ? dur(state_n) : cnt - 8'd1;
    end
    // ic_com is registered from the next state so the pins never see decode glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            clr_pend   <= 1'b0;
            data_q     <= 16'd0;
            upd_cnt    <= 16'd0;
            ic_q       <= 4'b1111;
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            clr_pend   <= !go_clr && (clr_pend || s.clr_req);
            data_q     <= go_clr ? 16'd0 : accept ? s.in_data : data_q;
            ic_q       <= com(state_n);
            wr_done_q  <= state == HOLD_DAC && last;
            clr_done_q <= state == HOLD_CLR && last;
            upd_cnt    <= upd_cnt + {15'd0, state == HOLD_DAC && last};
        end
    end
endmodule
